// File: rtl/pkg_spi.sv
// Shared types and constants for the quad-SPI register target and its host-side model.
package pkg_spi;

  typedef enum logic [1:0] {
    SIZE_BT = 2'd0,
    SIZE_HW = 2'd1,
    SIZE_WD = 2'd2
  } cmd_size_e;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    TURN,
    RDATA,
    HOLD
  } state_e;

  localparam int unsigned CMD_READ_BIT  = 7;
  localparam int unsigned DUMMY_NIBBLES = 2;
  localparam int unsigned NIB_CNT_W     = 4;

  // Nibbles carried by one access of the given size: 2, 4 or 8.
  function automatic logic [NIB_CNT_W-1:0] size_nibbles(input logic [1:0] size);
    return NIB_CNT_W'(2) << size;
  endfunction

  // Left-align right-aligned read data so the MSB nibble sits at [31:28].
  function automatic logic [31:0] rdata_align(input logic [31:0] data, input logic [1:0] size);
    case (size)
      SIZE_BT: return {data[7:0], 24'h0};
      SIZE_HW: return {data[15:0], 16'h0};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/qspi_edge_sync.sv
// Brings CS_N, SCK and COPI into the clk domain and flags edges of the synchronized CS_N and SCK.
module qspi_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n_raw,
  input  logic       sck_raw,
  input  logic [3:0] copi_raw,
  output logic [3:0] copi,
  output logic       sck_rise_c,
  output logic       sck_fall_c,
  output logic       cs_fall_c,
  output logic       cs_rise_c
);

  localparam int unsigned COPI_PIPE_W = 4 * SYNC_STAGES;

  logic [SYNC_STAGES-1:0] cs_pipe;
  logic [SYNC_STAGES-1:0] sck_pipe;
  logic [COPI_PIPE_W-1:0] copi_pipe;
  logic                   cs_prev;
  logic                   sck_prev;

  // New samples enter at the LSB end; the MSB end is the synchronized value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_pipe   <= '1;
      sck_pipe  <= '0;
      copi_pipe <= '0;
      cs_prev   <= 1'b1;
      sck_prev  <= 1'b0;
    end else begin
      cs_pipe   <= SYNC_STAGES'({cs_pipe, cs_n_raw});
      sck_pipe  <= SYNC_STAGES'({sck_pipe, sck_raw});
      copi_pipe <= COPI_PIPE_W'({copi_pipe, copi_raw});
      cs_prev   <= cs_pipe[SYNC_STAGES-1];
      sck_prev  <= sck_pipe[SYNC_STAGES-1];
    end
  end

  assign copi       = copi_pipe[COPI_PIPE_W-1 -: 4];
  assign sck_rise_c =  sck_pipe[SYNC_STAGES-1] & ~sck_prev;
  assign sck_fall_c = ~sck_pipe[SYNC_STAGES-1] &  sck_prev;
  assign cs_fall_c  = ~cs_pipe[SYNC_STAGES-1]  &  cs_prev;
  assign cs_rise_c  =  cs_pipe[SYNC_STAGES-1]  & ~cs_prev;

endmodule

// File: rtl/qspi_reg_target.sv
// Quad-SPI responder turning framed commands into single-cycle register-bus accesses.
// Define QSPI_REG_TARGET_BURST_EN to let reads and writes continue at incrementing addresses.
module qspi_reg_target
  import pkg_spi::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CS_N,
  input  logic              SCK,
  input  logic [3:0]        COPI,
  output logic [3:0]        CIPO,
  output logic              cipo_oe,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [1:0]        bus_size,
  output logic [31:0]       bus_wdata,
  output logic              bus_we,
  output logic              bus_re,
  input  logic [31:0]       bus_rdata,
  output logic              frame_err
);

  logic [3:0]           copi;
  logic                 sck_rise_c;
  logic                 sck_fall_c;
  logic                 cs_fall_c;
  logic                 cs_rise_c;

  state_e               state;
  logic [NIB_CNT_W-1:0] nib_cnt;
  logic [3:0]           hi_nib;
  logic                 is_read;
  logic [31:0]          shreg;
  logic [27:0]          wsh;
  logic                 rd_pend;
  logic [7:0]           rx_byte_c;
  logic                 cmd_bad_c;
  logic [NIB_CNT_W-1:0] n_c;
`ifdef QSPI_REG_TARGET_BURST_EN
  logic                 wr_started;
  logic [ADDR_W-1:0]    step_c;
`endif

  qspi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .cs_n_raw  (CS_N),
    .sck_raw   (SCK),
    .copi_raw  (COPI),
    .copi      (copi),
    .sck_rise_c(sck_rise_c),
    .sck_fall_c(sck_fall_c),
    .cs_fall_c (cs_fall_c),
    .cs_rise_c (cs_rise_c)
  );

  assign rx_byte_c = {hi_nib, copi};
  assign cmd_bad_c = (rx_byte_c[1:0] == 2'd3) || (rx_byte_c[6:2] != 5'd0);
  assign n_c       = size_nibbles(bus_size);
`ifdef QSPI_REG_TARGET_BURST_EN
  assign step_c    = ADDR_W'(1) << bus_size;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      nib_cnt    <= '0;
      hi_nib     <= '0;
      is_read    <= 1'b0;
      shreg      <= '0;
      wsh        <= '0;
      rd_pend    <= 1'b0;
`ifdef QSPI_REG_TARGET_BURST_EN
      wr_started <= 1'b0;
`endif
      CIPO       <= '0;
      cipo_oe    <= 1'b0;
      bus_addr   <= '0;
      bus_size   <= '0;
      bus_wdata  <= '0;
      bus_we     <= 1'b0;
      bus_re     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      bus_we  <= 1'b0;
      bus_re  <= 1'b0;
      rd_pend <= bus_re;
      // Register file answers one clk after bus_re.
      if (rd_pend) begin
        shreg <= rdata_align(bus_rdata, bus_size);
      end
      if (cs_rise_c) begin
        state   <= IDLE;
        cipo_oe <= 1'b0;
        CIPO    <= '0;
      end else if (cs_fall_c) begin
        state     <= CMD;
        nib_cnt   <= '0;
        frame_err <= 1'b0;
      end else begin
        case (state)
          CMD: begin
            if (sck_rise_c) begin
              if (nib_cnt == '0) begin
                hi_nib  <= copi;
                nib_cnt <= NIB_CNT_W'(1);
              end else begin
                nib_cnt <= '0;
                if (cmd_bad_c) begin
                  state     <= HOLD;
                  frame_err <= 1'b1;
                end else begin
                  is_read  <= rx_byte_c[CMD_READ_BIT];
                  bus_size <= rx_byte_c[1:0];
                  state    <= ADDR;
                end
              end
            end
          end
          ADDR: begin
            if (sck_rise_c) begin
              if (nib_cnt == '0) begin
                hi_nib  <= copi;
                nib_cnt <= NIB_CNT_W'(1);
              end else begin
                nib_cnt    <= '0;
                wsh        <= '0;
                bus_addr   <= ADDR_W'(rx_byte_c);
`ifdef QSPI_REG_TARGET_BURST_EN
                wr_started <= 1'b0;
`endif
                if (is_read) begin
                  bus_re <= 1'b1;
                  state  <= TURN;
                end else begin
                  state  <= WDATA;
                end
              end
            end
          end
          WDATA: begin
            if (sck_rise_c) begin
              if (nib_cnt == n_c - NIB_CNT_W'(1)) begin
                bus_we    <= 1'b1;
                bus_wdata <= {wsh, copi};
                wsh       <= '0;
                nib_cnt   <= '0;
`ifdef QSPI_REG_TARGET_BURST_EN
                if (wr_started) begin
                  bus_addr <= bus_addr + step_c;
                end
                wr_started <= 1'b1;
`else
                state <= HOLD;
`endif
              end else begin
                wsh     <= {wsh[23:0], copi};
                nib_cnt <= nib_cnt + NIB_CNT_W'(1);
              end
            end
          end
          // Dummy period: output enable at the first fall, first data nibble at the fall closing it.
          TURN: begin
            if (sck_fall_c) begin
              if (nib_cnt == '0) begin
                cipo_oe <= 1'b1;
              end
              if (nib_cnt == NIB_CNT_W'(DUMMY_NIBBLES)) begin
                CIPO    <= shreg[31:28];
                shreg   <= {shreg[27:0], 4'h0};
                nib_cnt <= NIB_CNT_W'(1);
                state   <= RDATA;
              end else begin
                nib_cnt <= nib_cnt + NIB_CNT_W'(1);
              end
            end
          end
          RDATA: begin
            if (sck_fall_c) begin
              if (nib_cnt == n_c) begin
                CIPO  <= '0;
                state <= HOLD;
              end else begin
                CIPO  <= shreg[31:28];
                shreg <= {shreg[27:0], 4'h0};
`ifdef QSPI_REG_TARGET_BURST_EN
                if (nib_cnt == n_c - NIB_CNT_W'(1)) begin
                  bus_re   <= 1'b1;
                  bus_addr <= bus_addr + step_c;
                  nib_cnt  <= '0;
                end else begin
                  nib_cnt <= nib_cnt + NIB_CNT_W'(1);
                end
`else
                nib_cnt <= nib_cnt + NIB_CNT_W'(1);
`endif
              end
            end
          end
          IDLE, HOLD: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_reg_target.sv
// Host-side model driving quad-SPI frames against a byte-array register file and a strobe scoreboard.
module tb_qspi_reg_target;
  import pkg_spi::*;

  localparam int ADDR_W    = 7;
  localparam int MEM_BYTES = 1 << ADDR_W;
  localparam int HALF      = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              CS_N = 1'b1;
  logic              SCK = 1'b0;
  logic [3:0]        COPI = 4'h0;
  logic [3:0]        CIPO;
  logic              cipo_oe;
  logic [ADDR_W-1:0] bus_addr;
  logic [1:0]        bus_size;
  logic [31:0]       bus_wdata;
  logic              bus_we;
  logic              bus_re;
  logic [31:0]       bus_rdata = 32'h0;
  logic              frame_err;

  int checks = 0;
  int errors = 0;

  logic [7:0]          mem [MEM_BYTES];
  logic [ADDR_W+1:0]   exp_re [$];
  logic [ADDR_W+33:0]  exp_we [$];

  qspi_reg_target #(.SYNC_STAGES(2), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .CS_N(CS_N), .SCK(SCK), .COPI(COPI), .CIPO(CIPO),
    .cipo_oe(cipo_oe), .bus_addr(bus_addr), .bus_size(bus_size), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input int addr, input int size);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < (1 << size); k++)
      v = v | (32'(mem[(addr + k) % MEM_BYTES]) << (8 * k));
    return v;
  endfunction

  function automatic void model_write(input int addr, input int size, input logic [31:0] data);
    for (int k = 0; k < (1 << size); k++)
      mem[(addr + k) % MEM_BYTES] = 8'(data >> (8 * k));
  endfunction

  // Register file: data valid only in the clk after bus_re, garbage otherwise.
  initial begin : responder
    logic pend;
    logic [ADDR_W-1:0] a;
    logic [1:0] s;
    pend = 1'b0;
    a = '0;
    s = '0;
    forever begin
      @(negedge clk);
      bus_rdata = pend ? model_read(int'(a), int'(s)) : $urandom;
      pend = bus_re && !rst;
      a = bus_addr;
      s = bus_size;
    end
  end

  // Scoreboard for bus strobes.
  initial begin : compare
    logic [ADDR_W+1:0]  er;
    logic [ADDR_W+33:0] ew;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus_re) begin
          if (exp_re.size() == 0) chk("unexpected_re", 32'(exp_re.size()), 32'd1);
          else begin
            er = exp_re.pop_front();
            chk("re_addr", 32'(bus_addr), 32'(er[ADDR_W+1:2]));
            chk("re_size", 32'(bus_size), 32'(er[1:0]));
          end
        end
        if (bus_we) begin
          if (exp_we.size() == 0) chk("unexpected_we", 32'(exp_we.size()), 32'd1);
          else begin
            ew = exp_we.pop_front();
            chk("we_addr", 32'(bus_addr), 32'(ew[ADDR_W+33:34]));
            chk("we_size", 32'(bus_size), 32'(ew[33:32]));
            chk("we_data", bus_wdata, ew[31:0]);
          end
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic nib(input logic [3:0] d, output logic [3:0] q, output logic oe);
    COPI = d;
    wait_clk(HALF);
    SCK = 1'b1;
    q = CIPO;
    oe = cipo_oe;
    wait_clk(HALF);
    SCK = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [3:0] q;
    logic oe;
    nib(b[7:4], q, oe);
    nib(b[3:0], q, oe);
  endtask

  task automatic cs_low();
    CS_N = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    CS_N = 1'b1;
    wait_clk(HALF);
  endtask

  function automatic logic [7:0] cmd_byte(input bit rd_flag, input int size);
    logic [7:0] c = 8'(size);
    c[CMD_READ_BIT] = rd_flag;
    return c;
  endfunction

  task automatic rd(input int size, input int addr, input int count, output logic [31:0] last);
    int n = 2 << size;
    int step = 1 << size;
    logic [3:0] q;
    logic oe;
    logic [31:0] exp, got;
    int pushes = count;
`ifdef QSPI_REG_TARGET_BURST_EN
    pushes = count + 1;
`endif
    last = 32'h0;
    for (int k = 0; k < pushes; k++)
      exp_re.push_back({ADDR_W'((addr + k * step) % MEM_BYTES), 2'(size)});
    cs_low();
    send_byte(cmd_byte(1'b1, size));
    send_byte(8'(addr));
    for (int i = 0; i < int'(DUMMY_NIBBLES); i++) begin
      nib(4'($urandom), q, oe);
      if (i == int'(DUMMY_NIBBLES) - 1) chk("turn_oe", 32'(oe), 32'd1);
    end
    for (int k = 0; k < count; k++) begin
      exp = model_read((addr + k * step) % MEM_BYTES, size);
      got = 32'h0;
      for (int i = 0; i < n; i++) begin
        nib(4'($urandom), q, oe);
        got = {got[27:0], q};
        chk("rd_nibble", 32'(q), 32'((exp >> (4 * (n - 1 - i))) & 32'hF));
        chk("rd_oe", 32'(oe), 32'd1);
      end
      chk("rd_data", got, exp);
      last = got;
    end
`ifndef QSPI_REG_TARGET_BURST_EN
    wait_clk(HALF);
    chk("hold_cipo", 32'(CIPO), 32'd0);
    chk("hold_oe", 32'(cipo_oe), 32'd1);
`endif
    cs_high();
    chk("rd_oe_off", 32'(cipo_oe), 32'd0);
    chk("rd_re_done", 32'(exp_re.size()), 32'd0);
    chk("rd_ferr", 32'(frame_err), 32'd0);
  endtask

  task automatic wr(input int size, input int addr, input logic [31:0] data, input int count,
                    input int extra);
    int n = 2 << size;
    int step = 1 << size;
    logic [31:0] mask = (size == 2) ? 32'hFFFF_FFFF : ((32'h1 << (8 * step)) - 32'h1);
    logic [31:0] v;
    logic [3:0] q;
    logic oe;
    for (int k = 0; k < count; k++) begin
      v = (data + 32'(k)) & mask;
      exp_we.push_back({ADDR_W'((addr + k * step) % MEM_BYTES), 2'(size), v});
      model_write((addr + k * step) % MEM_BYTES, size, v);
    end
    cs_low();
    send_byte(cmd_byte(1'b0, size));
    send_byte(8'(addr));
    for (int k = 0; k < count; k++) begin
      v = (data + 32'(k)) & mask;
      for (int i = 0; i < n; i++) nib(4'(v >> (4 * (n - 1 - i))), q, oe);
    end
    for (int e = 0; e < extra; e++) nib(4'($urandom), q, oe);
    cs_high();
    chk("we_done", 32'(exp_we.size()), 32'd0);
    chk("wr_oe", 32'(cipo_oe), 32'd0);
    chk("wr_ferr", 32'(frame_err), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cipo"}, 32'(CIPO), 32'd0);
    chk({tag, "_oe"}, 32'(cipo_oe), 32'd0);
    chk({tag, "_addr"}, 32'(bus_addr), 32'd0);
    chk({tag, "_size"}, 32'(bus_size), 32'd0);
    chk({tag, "_wdata"}, bus_wdata, 32'd0);
    chk({tag, "_we"}, 32'(bus_we), 32'd0);
    chk({tag, "_re"}, 32'(bus_re), 32'd0);
    chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
  endtask

  initial begin : watchdog
    #800000;
    errors++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] got;
    logic [3:0] q;
    logic oe;
    logic [7:0] bad_cmds [3];
    int s, a;
    bad_cmds = '{8'h03, 8'h84, 8'h20};
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);

    wait_clk(3);
    chk_reset_outputs("rst_hold");
    rst = 1'b0;
    wait_clk(HALF);
    chk_reset_outputs("rst_rel");

    // Byte read at 0 returning 0x55.
    mem[0] = 8'h55;
    rd(int'(SIZE_BT), 0, 1, got);
    chk("lit_rd55", got, 32'h55);

    // Halfword 11 at 12, read back.
    wr(int'(SIZE_HW), 12, 32'd11, 1, 0);
    rd(int'(SIZE_HW), 12, 1, got);
    chk("lit_hw12", got, 32'h0000_000B);

    // Word at 112 with trailing SCK edges that must not start another write.
    wr(int'(SIZE_WD), 112, 32'h00AA_AAAA, 1, 2);
    chk("lit_wd112_model", model_read(112, int'(SIZE_WD)), 32'h00AA_AAAA);
    rd(int'(SIZE_WD), 112, 1, got);
    chk("lit_wd112", got, 32'h00AA_AAAA);

    // Partial word write: 5 of 8 nibbles.
    cs_low();
    send_byte(cmd_byte(1'b0, int'(SIZE_WD)));
    send_byte(8'd40);
    for (int i = 0; i < 5; i++) nib(4'($urandom), q, oe);
    cs_high();
    chk("partial_oe", 32'(cipo_oe), 32'd0);
    chk("partial_ferr", 32'(frame_err), 32'd0);
    rd(int'(SIZE_BT), 1, 1, got);

    // Invalid commands.
    foreach (bad_cmds[j]) begin
      cs_low();
      send_byte(bad_cmds[j]);
      wait_clk(HALF);
      chk("ferr_set", 32'(frame_err), 32'd1);
      send_byte(8'h10);
      for (int i = 0; i < 4; i++) nib(4'($urandom), q, oe);
      chk("ferr_oe", 32'(cipo_oe), 32'd0);
      cs_high();
      chk("ferr_sticky", 32'(frame_err), 32'd1);
      cs_low();
      chk("ferr_clear", 32'(frame_err), 32'd0);
      cs_high();
    end

`ifdef QSPI_REG_TARGET_BURST_EN
    wr(int'(SIZE_HW), 20, 32'h05AA, 3, 0);
    chk("lit_burst_mem", model_read(24, int'(SIZE_HW)), 32'h05AC);
    rd(int'(SIZE_HW), 20, 3, got);
    chk("lit_burst_rd", got, 32'h05AC);
`endif

    // Randomized traffic, including wrap at the top of the space.
    for (int t = 0; t < 40; t++) begin
      s = int'($urandom_range(0, 2));
      a = int'($urandom_range(0, MEM_BYTES - 1));
      if ($urandom_range(0, 1) == 1) wr(s, a, $urandom, 1, 0);
      else rd(s, a, 1, got);
    end

    // Reset in the middle of a word read.
    exp_re.push_back({ADDR_W'(64), 2'(SIZE_WD)});
    cs_low();
    send_byte(cmd_byte(1'b1, int'(SIZE_WD)));
    send_byte(8'd64);
    for (int i = 0; i < int'(DUMMY_NIBBLES) + 3; i++) nib(4'($urandom), q, oe);
    chk("pre_rst_oe", 32'(cipo_oe), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    CS_N = 1'b1;
    SCK = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(HALF);
    chk_reset_outputs("rst_after");
    chk("rst_re_done", 32'(exp_re.size()), 32'd0);
    rd(int'(SIZE_WD), 64, 1, got);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
